alu_input_seq: RTL and testbench
================================

// Module: alu_input_seq
// PURPOSE
//   Upstream operand sequencer and result latch for the 4-bit ALU. One board button steps through the
//   states that load A, load B and load the opcode from the switches, then registers the ALU response.
//   The registered o_a/o_b/o_op drive the ALU inputs. The ALU's result, carry and overflow return to this
//   block, which holds them stable for the display stage.
// PARAMETERS
//   DB_CYCLES    1000000  consecutive cycles a synced button level must differ from the debounced level
//                         before the debounced level updates (20 ms at 50 MHz)
//   DB_CNT_W     20       debounce counter width; must satisfy 2**DB_CNT_W >= DB_CYCLES
// PORTS
//   i_clk         in   1  system clock, all logic on its rising edge
//   i_rst_n       in   1  reset, asynchronous assert, active-low
//   i_btn         in   1  raw step button, active-high, asynchronous/bouncy
//   i_clr         in   1  synchronous clear, active-high, already clean
//   i_sw          in   4  operand switches (A or B)
//   i_sw_op       in   3  opcode switches
//   i_result      in   4  ALU result (combinational from o_a/o_b/o_op)
//   i_carry       in   1  ALU carry flag
//   i_overflow    in   1  ALU overflow flag
//   o_a           out  4  registered operand A to ALU
//   o_b           out  4  registered operand B to ALU
//   o_op          out  3  registered opcode to ALU
//   o_res_q       out  4  captured result
//   o_carry_q     out  1  captured carry
//   o_overflow_q  out  1  captured overflow
//   o_valid       out  1  one-cycle pulse when a capture completes
//   o_state       out  3  current FSM state, for status LEDs
// BEHAVIOUR
//   Reset: all outputs and registers 0. o_state=S_A. Sync flops, debounced level and counter are 0.
//   Synchronizer: i_btn passes through 2 flops -> btn_s.
//   Debounce:
//   - If btn_s==db_lvl, cnt<=0.
//   - Otherwise cnt increments. When cnt==DB_CYCLES-1, db_lvl<=btn_s and cnt<=0.
//   - press = db_lvl & ~db_lvl_d, a one-cycle pulse.
//   - Raw edge to press latency: 2 + DB_CYCLES + 1 cycles.
//   FSM encoding: S_A=0, S_B=1, S_OP=2, S_CAP=3, S_SHOW=4. Unused codes return to S_A on the next cycle.
//   - S_A    + press: o_a<=i_sw, go to S_B.
//   - S_B    + press: o_b<=i_sw, go to S_OP.
//   - S_OP   + press: o_op<=i_sw_op, go to S_CAP.
//   - S_CAP  (exactly 1 cycle, ALU inputs now stable): o_res_q<=i_result, o_carry_q<=i_carry,
//            o_overflow_q<=i_overflow, o_valid<=1 (visible in the first S_SHOW cycle), go to S_SHOW.
//   - S_SHOW + press: go to S_A. o_a/o_b/o_op/o_res_q and flags are held until overwritten.
//   - A press arriving in S_CAP is dropped.
//   i_clr has top priority over press. Next cycle: state=S_A, and o_a, o_b, o_op, o_res_q, flags and
//   o_valid are all 0. The debouncer is not cleared.
//   Reset assertion mid-sequence takes effect immediately and asynchronously. There is no partial load.
//   Captured values are taken verbatim from the ALU. An overflowing add therefore stores i_result=0 with
//   o_overflow_q=1.
// CONFIGURATION
//   ALU_SEQ_LIVE_EN
//   - Defined: in S_SHOW, o_op<=i_sw_op every cycle, and o_res_q/o_carry_q/o_overflow_q re-register the
//     ALU outputs every cycle (1-cycle lag). o_valid pulses whenever o_res_q changes.
//   - Undefined: S_SHOW values stay frozen and o_valid pulses only after S_CAP.
// TESTING   (DB_CYCLES=4, DB_CNT_W=3, macro off unless stated)
//   1. Hold i_btn high for 10 cycles, toggling for 2 cycles at the start -> exactly one press. S_A->S_B.
//   2. Load sequence i_sw=3, press; i_sw=2, press; i_sw_op=000, press -> o_a=3, o_b=2, o_op=0.
//      One o_valid pulse follows, with o_res_q=5, o_carry_q=0, o_overflow_q=0, o_state=4.
//   3. Load A=7, B=1, op=000 -> o_overflow_q=1, o_res_q=0. Press in S_SHOW -> o_state=0, values held.
//   4. Glitch i_btn high for 3 cycles only -> no press, state unchanged.
//   5. i_clr in S_B, with o_a=5 -> next cycle o_state=0, o_a=0. Drop i_rst_n in S_OP -> all outputs 0
//      immediately.
//   6. Macro on: in S_SHOW with A=6, B=3, op=011 (o_res_q=2), change i_sw_op to 100 -> o_op=4 one cycle
//      later. o_res_q=7 the cycle after that, with one o_valid pulse.

Source files
------------

// File: rtl/alu_input_seq.sv
// alu_input_seq: button-stepped operand sequencer (A, B, opcode) and result latch for a 4-bit ALU.
// Latency: raw button edge to FSM step is 2 sync + DB_CYCLES debounce + 1 cycles; capture is 1 cycle after opcode load.
// Backpressure: none; presses arriving in S_CAP are dropped, i_clr overrides any press.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_btn                     raw bouncy step button (active-high)
//   i_clr                     clean synchronous clear (active-high)
//   i_sw, i_sw_op             operand / opcode switches
//   i_result/i_carry/i_overflow  combinational ALU response to o_a/o_b/o_op
//   o_a, o_b, o_op            registered ALU inputs
//   o_res_q/o_carry_q/o_overflow_q  captured ALU response
//   o_valid                   one-cycle pulse when a capture lands
//   o_state                   FSM state for status LEDs
//
// Build option: ALU_SEQ_LIVE_EN -- when defined, S_SHOW tracks the opcode switches and
// re-registers the ALU response every cycle, pulsing o_valid whenever the result changes.
module alu_input_seq #(
  parameter int DB_CYCLES = 1000000,
  parameter int DB_CNT_W  = 20
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_btn,
  input  logic       i_clr,
  input  logic [3:0] i_sw,
  input  logic [2:0] i_sw_op,
  input  logic [3:0] i_result,
  input  logic       i_carry,
  input  logic       i_overflow,
  output logic [3:0] o_a,
  output logic [3:0] o_b,
  output logic [2:0] o_op,
  output logic [3:0] o_res_q,
  output logic       o_carry_q,
  output logic       o_overflow_q,
  output logic       o_valid,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_CAP  = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_CYCLES - 1);

  // ---------------- synchronizer + debouncer ----------------
  logic                sync1_q, sync2_q;
  logic                db_lvl_q, db_lvl_d;
  logic                db_lvl_dly_q;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;
  logic                press;

  always_comb begin
    db_lvl_d = db_lvl_q;
    cnt_d    = '0;
    if (sync2_q != db_lvl_q) begin
      if (cnt_q == CNT_LAST) begin
        db_lvl_d = sync2_q;
      end else begin
        cnt_d = cnt_q + DB_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      db_lvl_q     <= 1'b0;
      db_lvl_dly_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= i_btn;
      sync2_q      <= sync1_q;
      db_lvl_q     <= db_lvl_d;
      db_lvl_dly_q <= db_lvl_q;
      cnt_q        <= cnt_d;
    end
  end

  // Rising edge of the debounced level; release edges never step the FSM.
  assign press = db_lvl_q & ~db_lvl_dly_q;

  // ---------------- sequencer FSM and data registers ----------------
  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [2:0] op_q, op_d;
  logic [3:0] res_q, res_d;
  logic       carry_q, carry_d;
  logic       ovf_q, ovf_d;
  logic       valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;

    if (i_clr) begin
      // Clear wipes the datapath but leaves the debouncer alone.
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      res_d   = '0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        S_A: begin
          if (press) begin
            a_d     = i_sw;
            state_d = S_B;
          end
        end
        S_B: begin
          if (press) begin
            b_d     = i_sw;
            state_d = S_OP;
          end
        end
        S_OP: begin
          if (press) begin
            op_d    = i_sw_op;
            state_d = S_CAP;
          end
        end
        S_CAP: begin
          // ALU inputs settled during the previous cycle; press here is ignored.
          res_d   = i_result;
          carry_d = i_carry;
          ovf_d   = i_overflow;
          valid_d = 1'b1;
          state_d = S_SHOW;
        end
        S_SHOW: begin
`ifdef ALU_SEQ_LIVE_EN
          op_d    = i_sw_op;
          res_d   = i_result;
          carry_d = i_carry;
          ovf_d   = i_overflow;
          valid_d = (i_result != res_q);
`endif
          if (press) begin
            state_d = S_A;
          end
        end
        default: begin
          state_d = S_A;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign o_a          = a_q;
  assign o_b          = b_q;
  assign o_op         = op_q;
  assign o_res_q      = res_q;
  assign o_carry_q    = carry_q;
  assign o_overflow_q = ovf_q;
  assign o_valid      = valid_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_alu_input_seq.sv
// tb_alu_input_seq: directed bench for alu_input_seq with a scoreboard on o_valid captures.
// Latency: press task allows 8 cycles for debounce of each edge (DB_CYCLES=4).
// Backpressure: none; the monitor pops one expected capture per o_valid pulse.
module tb_alu_input_seq;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_btn;
  logic       i_clr;
  logic [3:0] i_sw;
  logic [2:0] i_sw_op;
  logic [3:0] i_result;
  logic       i_carry;
  logic       i_overflow;
  logic [3:0] o_a;
  logic [3:0] o_b;
  logic [2:0] o_op;
  logic [3:0] o_res_q;
  logic       o_carry_q;
  logic       o_overflow_q;
  logic       o_valid;
  logic [2:0] o_state;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct packed {
    logic [3:0] res;
    logic       c;
    logic       v;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
  } exp_t;

  exp_t exp_q[$];

  always #5 i_clk = ~i_clk;

  alu_input_seq #(.DB_CYCLES(4), .DB_CNT_W(3)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn), .i_clr(i_clr),
    .i_sw(i_sw), .i_sw_op(i_sw_op), .i_result(i_result), .i_carry(i_carry),
    .i_overflow(i_overflow), .o_a(o_a), .o_b(o_b), .o_op(o_op),
    .o_res_q(o_res_q), .o_carry_q(o_carry_q), .o_overflow_q(o_overflow_q),
    .o_valid(o_valid), .o_state(o_state)
  );

  // ALU stand-in: 000 add (result blanked to 0 on signed overflow), 011 and, 100 or.
  always_comb begin
    logic [4:0] sum;
    sum        = {1'b0, o_a} + {1'b0, o_b};
    i_result   = 4'd0;
    i_carry    = 1'b0;
    i_overflow = 1'b0;
    case (o_op)
      3'b000: begin
        i_carry    = sum[4];
        i_overflow = (o_a[3] == o_b[3]) && (sum[3] != o_a[3]);
        i_result   = i_overflow ? 4'd0 : sum[3:0];
      end
      3'b011:  i_result = o_a & o_b;
      3'b100:  i_result = o_a | o_b;
      default: i_result = 4'd0;
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every o_valid pulse must match the oldest expected capture.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (i_rst_n === 1'b1 && o_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_valid: got o_valid=1 with res=%0d, expected no pulse", o_res_q);
        end else begin
          e = exp_q.pop_front();
          chk("cap_res",   int'(o_res_q),      int'(e.res));
          chk("cap_carry", int'(o_carry_q),    int'(e.c));
          chk("cap_ovf",   int'(o_overflow_q), int'(e.v));
          chk("cap_a",     int'(o_a),          int'(e.a));
          chk("cap_b",     int'(o_b),          int'(e.b));
          chk("cap_op",    int'(o_op),         int'(e.op));
          chk("cap_state", int'(o_state),      4);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  task automatic press();
    @(negedge i_clk);
    i_btn = 1'b1;
    repeat (8) @(negedge i_clk);
    i_btn = 1'b0;
    repeat (8) @(negedge i_clk);
  endtask

  task automatic load(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    i_sw = a;
    press();
    i_sw = b;
    press();
    i_sw_op = op;
    press();
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_btn   = 1'b0;
    i_clr   = 1'b0;
    i_sw    = 4'd0;
    i_sw_op = 3'd0;
    repeat (3) @(negedge i_clk);
    chk("rst_state", int'(o_state), 0);
    chk("rst_a",     int'(o_a), 0);
    chk("rst_res",   int'(o_res_q), 0);
    chk("rst_valid", int'(o_valid), 0);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    // Bouncy press: toggle at the start, then hold -> exactly one step.
    i_sw = 4'd3;
    @(negedge i_clk); i_btn = 1'b1;
    @(negedge i_clk); i_btn = 1'b0;
    @(negedge i_clk); i_btn = 1'b1;
    repeat (8) @(negedge i_clk);
    i_btn = 1'b0;
    repeat (8) @(negedge i_clk);
    chk("bounce_state", int'(o_state), 1);
    chk("bounce_a",     int'(o_a), 3);

    // Finish 3 + 2 add.
    i_sw = 4'd2;
    press();
    chk("loadb_b", int'(o_b), 2);
    i_sw_op = 3'b000;
    exp_q.push_back('{res: 4'd5, c: 1'b0, v: 1'b0, a: 4'd3, b: 4'd2, op: 3'd0});
    press();
    chk("show_state", int'(o_state), 4);

    press();
    chk("return_state", int'(o_state), 0);

    // 7 + 1 overflows: ALU presents 0 with overflow set.
    exp_q.push_back('{res: 4'd0, c: 1'b0, v: 1'b1, a: 4'd7, b: 4'd1, op: 3'd0});
    load(4'd7, 4'd1, 3'b000);
    press();
    chk("ovf_ret_state", int'(o_state), 0);
    chk("ovf_held_res",  int'(o_res_q), 0);
    chk("ovf_held_flag", int'(o_overflow_q), 1);
    chk("ovf_held_a",    int'(o_a), 7);

    // Short glitch must not step.
    @(negedge i_clk); i_btn = 1'b1;
    repeat (3) @(negedge i_clk);
    i_btn = 1'b0;
    repeat (10) @(negedge i_clk);
    chk("glitch_state", int'(o_state), 0);

    // Clear in S_B.
    i_sw = 4'd5;
    press();
    chk("preclr_a", int'(o_a), 5);
    @(negedge i_clk); i_clr = 1'b1;
    @(negedge i_clk); i_clr = 1'b0;
    chk("clr_state", int'(o_state), 0);
    chk("clr_a",     int'(o_a), 0);
    chk("clr_ovf",   int'(o_overflow_q), 0);

    // Reset dropped in S_OP acts without a clock edge.
    i_sw = 4'd9;
    press();
    i_sw = 4'd4;
    press();
    chk("prerst_state", int'(o_state), 2);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    chk("arst_state", int'(o_state), 0);
    chk("arst_a",     int'(o_a), 0);
    chk("arst_b",     int'(o_b), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    // 6 & 3 = 2, then change the opcode switches while showing.
    exp_q.push_back('{res: 4'd2, c: 1'b0, v: 1'b0, a: 4'd6, b: 4'd3, op: 3'b011});
    load(4'd6, 4'd3, 3'b011);
    chk("and_state", int'(o_state), 4);
`ifdef ALU_SEQ_LIVE_EN
    exp_q.push_back('{res: 4'd7, c: 1'b0, v: 1'b0, a: 4'd6, b: 4'd3, op: 3'b100});
    i_sw_op = 3'b100;
    @(negedge i_clk);
    chk("live_op",     int'(o_op), 4);
    chk("live_res_lag", int'(o_res_q), 2);
    @(negedge i_clk);
    chk("live_res",    int'(o_res_q), 7);
    repeat (3) @(negedge i_clk);
`else
    i_sw_op = 3'b100;
    repeat (4) @(negedge i_clk);
    chk("frozen_op",  int'(o_op), 3);
    chk("frozen_res", int'(o_res_q), 2);
`endif

    repeat (5) @(negedge i_clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
